fc_accumulator: RTL and testbench

Downstream neighbour of the FC-layer fixed-point multiplier. It consumes that multiplier's rounded, saturated 16Q11 products, one per cycle. It sums one neuron's products onto a preloaded bias, applies optional ReLU, saturates the result to 16Q11, and presents it through a valid/ready output handshake. One instance handles one neuron at a time; the layer controller issues `start` per neuron.

---
 rtl/fc_pkg.sv | 19 +
 rtl/fc_sat_clamp.sv | 26 ++
 rtl/fc_accumulator.sv | 132 +++++++++++++
 tb/tb_fc_accumulator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and 16Q11 fixed-point constants for the FC-layer neuron accumulator.
package fc_pkg;

    localparam int DWIDTH    = 16;
    localparam int QWIDTH    = 11;
    localparam int AWIDTH    = 24;
    localparam int CNT_WIDTH = 9;

    localparam logic [DWIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DWIDTH-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SAT,
        OUT
    } state_e;

endpackage

// File: rtl/fc_sat_clamp.sv
// Combinational signed width reducer: passes the value through when it fits in OUT_W,
// otherwise clamps to the OUT_W signed max/min and raises clamped.
module fc_sat_clamp #(
    parameter int IN_W  = 25,
    parameter int OUT_W = 24
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             clamped
);

    logic fits;

    always_comb begin
        fits    = (din[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){din[IN_W-1]}});
        clamped = !fits;
        if (fits) begin
            dout = din[OUT_W-1:0];
        end else if (din[IN_W-1]) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fc_accumulator.sv
// Sums one neuron's 16Q11 products onto its bias, optional ReLU, saturates to 16Q11; result 2 cycles after last product.
// Upstream products cannot be stalled; the result is held in OUT until dout_ready accepts it.
module fc_accumulator #(
    parameter int DWIDTH    = fc_pkg::DWIDTH,
    parameter int AWIDTH    = fc_pkg::AWIDTH,
    parameter int CNT_WIDTH = fc_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic [DWIDTH-1:0]    bias,
    input  logic                 relu_en,
    input  logic                 prod_valid,
    input  logic [DWIDTH-1:0]    prod_in,
    output logic                 busy,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [DWIDTH-1:0]    dout,
    output logic                 sat_flag
);
    import fc_pkg::*;

    state_e               state_q, state_d;
    logic [AWIDTH-1:0]    acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic                 relu_q, relu_d;
    logic [DWIDTH-1:0]    dout_q, dout_d;
    logic                 sat_q, sat_d;
    logic                 dout_valid_q, dout_valid_d;

    logic [AWIDTH:0]      sum_wide;
    logic [AWIDTH-1:0]    sum_clamped;
    logic                 sum_sat;
    logic [DWIDTH-1:0]    out_clamped;
    logic                 out_sat;
    logic                 relu_zero;

    // One guard bit above the accumulator so a single product can never wrap before the clamp.
    assign sum_wide = {acc_q[AWIDTH-1], acc_q}
                    + {{(AWIDTH+1-DWIDTH){prod_in[DWIDTH-1]}}, prod_in};

    fc_sat_clamp #(.IN_W(AWIDTH+1), .OUT_W(AWIDTH)) u_acc_clamp (
        .din     (sum_wide),
        .dout    (sum_clamped),
        .clamped (sum_sat)
    );

    fc_sat_clamp #(.IN_W(AWIDTH), .OUT_W(DWIDTH)) u_out_clamp (
        .din     (acc_q),
        .dout    (out_clamped),
        .clamped (out_sat)
    );

    assign relu_zero = relu_q && acc_q[AWIDTH-1];

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        relu_d       = relu_q;
        dout_d       = dout_q;
        sat_d        = sat_q;
        dout_valid_d = dout_valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    relu_d  = relu_en;
                    acc_d   = {{(AWIDTH-DWIDTH){bias[DWIDTH-1]}}, bias};
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = (len == '0) ? SAT : ACCUM;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
                    acc_d = sum_clamped;
                    sat_d = sat_q | sum_sat;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = SAT;
                    end
                end
            end
            SAT: begin
                // ReLU wins over clamping: a negative sum is forced to zero without flagging.
                dout_d       = relu_zero ? '0 : out_clamped;
                sat_d        = sat_q | (out_sat && !relu_zero);
                dout_valid_d = 1'b1;
                state_d      = OUT;
            end
            OUT: begin
                if (dout_ready) begin
                    dout_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            relu_q       <= 1'b0;
            dout_q       <= '0;
            sat_q        <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            relu_q       <= relu_d;
            dout_q       <= dout_d;
            sat_q        <= sat_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign sat_flag   = sat_q;

endmodule

// File: tb/tb_fc_accumulator.sv
// Scoreboard bench for fc_accumulator: expected results queued at start, compared on each output handshake.
module tb_fc_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  len;
    logic [15:0] bias;
    logic        relu_en;
    logic        prod_valid;
    logic [15:0] prod_in;
    logic        busy;
    logic        dout_valid;
    logic        dout_ready;
    logic [15:0] dout;
    logic        sat_flag;

    typedef struct packed {
        logic [15:0] dout;
        logic        sat;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] prod_tbl[16];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    fc_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .bias       (bias),
        .relu_en    (relu_en),
        .prod_valid (prod_valid),
        .prod_in    (prod_in),
        .busy       (busy),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .sat_flag   (sat_flag)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 24-bit saturating accumulate, then ReLU or 16-bit clamp.
    function automatic exp_t model(input int n, input logic [15:0] b, input logic r);
        longint acc;
        exp_t   e;
        e.sat = 1'b0;
        acc   = longint'($signed(b));
        for (int i = 0; i < n; i++) begin
            acc = acc + longint'($signed(prod_tbl[i]));
            if (acc > 64'sd8388607) begin
                acc = 64'sd8388607;  e.sat = 1'b1;
            end else if (acc < -64'sd8388608) begin
                acc = -64'sd8388608; e.sat = 1'b1;
            end
        end
        if (r && acc < 0) begin
            e.dout = 16'h0000;
        end else if (acc > 64'sd32767) begin
            e.dout = 16'h7FFF; e.sat = 1'b1;
        end else if (acc < -64'sd32768) begin
            e.dout = 16'h8000; e.sat = 1'b1;
        end else begin
            e.dout = acc[15:0];
        end
        return e;
    endfunction

    // Output side of the scoreboard: inputs change 2ns after posedge, so negedge sees the handshake values.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && dout_valid && dout_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("output_without_expectation", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq("dout", 32'(dout), 32'(e.dout));
                check_eq("sat_flag", 32'(sat_flag), 32'(e.sat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_basic();
        prod_tbl[0] = 16'h0800; prod_tbl[1] = 16'h0400;
        prod_tbl[2] = 16'hFC00; prod_tbl[3] = 16'h0200;
    endtask

    task automatic fill_tbl(input logic [15:0] v);
        for (int i = 0; i < 16; i++) prod_tbl[i] = v;
    endtask

    // Issues one neuron and leaves the bench in the first cycle where dout_valid is high.
    task automatic run_neuron(input int n, input logic [15:0] b, input logic r,
                              input int gap, input bit chk_lat, input string tag);
        int cyc;
        sb_q.push_back(model(n, b, r));
        start = 1'b1; len = 9'(n); bias = b; relu_en = r;
        step();
        start = 1'b0; len = 9'($urandom_range(0, 511)); bias = 16'($urandom);
        for (int i = 0; i < n; i++) begin
            prod_valid = 1'b1; prod_in = prod_tbl[i];
            step();
            prod_valid = 1'b0; prod_in = 16'($urandom);
            if (i < n - 1) repeat (gap) step();
        end
        cyc = 1;
        while (!dout_valid && cyc < 200) begin
            step();
            cyc++;
        end
        if (!dout_valid) check_eq({tag, "_timeout"}, 32'(dout_valid), 32'd1);
        if (chk_lat) check_eq({tag, "_latency"}, 32'(cyc), 32'd2);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (dout_valid && t < 200) begin
            step();
            t++;
        end
        check_eq({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; bias = '0; relu_en = 1'b0;
        prod_valid = 1'b0; prod_in = '0; dout_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_dout_valid", 32'(dout_valid), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_sat_flag", 32'(sat_flag), 32'd0);
        step();

        // Basic sum with latency check
        load_basic();
        run_neuron(4, 16'h0800, 1'b0, 0, 1'b1, "basic");
        drain("basic");

        // Products before start are ignored; gaps between products are legal
        for (int i = 0; i < 3; i++) begin
            prod_valid = 1'b1; prod_in = 16'h7000;
            step();
        end
        prod_valid = 1'b0;
        run_neuron(4, 16'h0800, 1'b0, 3, 1'b1, "gaps");
        drain("gaps");

        fill_tbl(16'h7FFF);
        run_neuron(8, 16'h0000, 1'b0, 0, 1'b0, "sat_pos");
        drain("sat_pos");
        fill_tbl(16'h8000);
        run_neuron(8, 16'h0000, 1'b0, 1, 1'b0, "sat_neg");
        drain("sat_neg");

        fill_tbl(16'h0000);
        run_neuron(1, 16'hF000, 1'b1, 0, 1'b0, "relu_on");
        drain("relu_on");
        run_neuron(1, 16'hF000, 1'b0, 0, 1'b0, "relu_off");
        drain("relu_off");
        run_neuron(0, 16'h0C00, 1'b1, 0, 1'b0, "len0");
        drain("len0");

        // Backpressure: result must hold while start/prod_valid are pulsed
        fill_tbl(16'h7FFF);
        dout_ready = 1'b0;
        run_neuron(8, 16'h0000, 1'b0, 0, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; len = 9'd3; prod_valid = 1'b1; prod_in = 16'h1234;
            step();
            check_eq("bp_dout_hold", 32'(dout), 32'h7FFF);
            check_eq("bp_sat_hold", 32'(sat_flag), 32'd1);
            check_eq("bp_valid_hold", 32'(dout_valid), 32'd1);
            check_eq("bp_busy", 32'(busy), 32'd1);
        end
        prod_valid = 1'b0;
        dout_ready = 1'b1;
        step();
        start = 1'b0;
        check_eq("bp_post_valid", 32'(dout_valid), 32'd0);
        check_eq("bp_post_busy", 32'(busy), 32'd0);
        step();
        check_eq("bp_no_restart", 32'(busy), 32'd0);

        // Reset after 2 of 4 products: no output, then a clean run
        load_basic();
        start = 1'b1; len = 9'd4; bias = 16'h4000; relu_en = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1; prod_in = 16'h3000;
            step();
        end
        prod_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_valid", 32'(dout_valid), 32'd0);
        check_eq("mid_rst_dout", 32'(dout), 32'd0);
        repeat (3) step();
        check_eq("mid_rst_still_idle", 32'(dout_valid), 32'd0);
        run_neuron(4, 16'h0800, 1'b0, 0, 1'b1, "after_rst");
        drain("after_rst");

        repeat (3) step();
        check_eq("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
